// File: rtl/lh_lookup.sv
// Flow-table lookup for per-packet logic hashes: input FIFO, one-at-a-time table read, tag compare.
// Optional statistics counters are built only when LH_LOOKUP_STATS_EN is defined.
`ifndef LOGIC_HASH_NBITS
`define LOGIC_HASH_NBITS 16
`endif

module lh_lookup #(
   parameter int LOGIC_HASH_NBITS = `LOGIC_HASH_NBITS,
   parameter int TBL_AW           = 10,
   parameter int FLOW_ID_NBITS    = 12,
   parameter int FIFO_DEPTH       = 4,
   parameter int RD_LAT           = 2
) (
   input  logic                                               clk_i,
   input  logic                                               rst_i,
   input  logic                                               lh_valid_i,
   input  logic [LOGIC_HASH_NBITS-1:0]                        lh_data_i,
   output logic                                               tbl_rd_en_o,
   output logic [TBL_AW-1:0]                                  tbl_rd_addr_o,
   input  logic [LOGIC_HASH_NBITS-TBL_AW+FLOW_ID_NBITS:0]     tbl_rd_data_i,
   output logic                                               lu_valid_o,
   input  logic                                               lu_ready_i,
   output logic                                               lu_hit_o,
   output logic [FLOW_ID_NBITS-1:0]                           lu_flow_id_o,
   output logic [LOGIC_HASH_NBITS-1:0]                        lu_hash_o,
   output logic [15:0]                                        drop_cnt_o,
   output logic [15:0]                                        hit_cnt_o
);

   localparam int TAG_W = LOGIC_HASH_NBITS - TBL_AW;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(RD_LAT + 1);
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                      state_q;
   logic [LOGIC_HASH_NBITS-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W:0]              wr_ptr_q;
   logic [PTR_W:0]              rd_ptr_q;
   logic [CNT_W-1:0]            wait_cnt_q;
   logic [LOGIC_HASH_NBITS-1:0] hash_q;
   logic                        tbl_rd_en_q;
   logic                        lu_valid_q;
   logic                        lu_hit_q;
   logic [FLOW_ID_NBITS-1:0]    lu_flow_id_q;
   logic [LOGIC_HASH_NBITS-1:0] lu_hash_q;

   logic [PTR_W:0]              fifo_cnt_s;
   logic                        fifo_empty_s;
   logic                        fifo_full_s;
   logic                        pop_s;
   logic                        push_s;
   logic                        fifo_nz_d_s;
   logic [LOGIC_HASH_NBITS-1:0] head_s;
   logic                        ent_valid_s;
   logic [TAG_W-1:0]            ent_tag_s;
   logic [FLOW_ID_NBITS-1:0]    ent_flow_s;
   logic                        hit_s;

   assign fifo_cnt_s    = wr_ptr_q - rd_ptr_q;
   assign fifo_empty_s  = (fifo_cnt_s == '0);
   assign fifo_full_s   = (fifo_cnt_s == FIFO_FULL);
   assign pop_s         = (state_q == ST_IDLE) && !fifo_empty_s;
   assign push_s        = lh_valid_i && (!fifo_full_s || pop_s);
   // FIFO occupancy after this cycle, valid whenever no pop happens this cycle.
   assign fifo_nz_d_s   = !fifo_empty_s || push_s;
   assign head_s        = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign tbl_rd_addr_o = head_s[TBL_AW-1:0];

   assign ent_valid_s = tbl_rd_data_i[TAG_W+FLOW_ID_NBITS];
   assign ent_tag_s   = tbl_rd_data_i[TAG_W+FLOW_ID_NBITS-1:FLOW_ID_NBITS];
   assign ent_flow_s  = tbl_rd_data_i[FLOW_ID_NBITS-1:0];
   assign hit_s       = ent_valid_s && (ent_tag_s == hash_q[LOGIC_HASH_NBITS-1:TBL_AW]);

   // Input queue: pointer update and storage write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_s) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= lh_data_i;
            wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
         end
      end
   end

   // Lookup FSM with registered read strobe and result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         tbl_rd_en_q  <= 1'b0;
         wait_cnt_q   <= '0;
         hash_q       <= '0;
         lu_valid_q   <= 1'b0;
         lu_hit_q     <= 1'b0;
         lu_flow_id_q <= '0;
         lu_hash_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop_s) begin
                  state_q     <= ST_READ;
                  tbl_rd_en_q <= 1'b0;
                  wait_cnt_q  <= CNT_W'(RD_LAT);
                  hash_q      <= head_s;
               end else begin
                  tbl_rd_en_q <= fifo_nz_d_s;
               end
            end
            ST_READ: begin
               tbl_rd_en_q <= 1'b0;
               if (wait_cnt_q == CNT_W'(1)) begin
                  state_q      <= ST_RESP;
                  lu_valid_q   <= 1'b1;
                  lu_hit_q     <= hit_s;
                  lu_flow_id_q <= hit_s ? ent_flow_s : {FLOW_ID_NBITS{1'b0}};
                  lu_hash_q    <= hash_q;
               end else begin
                  wait_cnt_q <= wait_cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (lu_ready_i) begin
                  state_q     <= ST_IDLE;
                  lu_valid_q  <= 1'b0;
                  tbl_rd_en_q <= fifo_nz_d_s;
               end else begin
                  tbl_rd_en_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               tbl_rd_en_q <= 1'b0;
               lu_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tbl_rd_en_o  = tbl_rd_en_q;
   assign lu_valid_o   = lu_valid_q;
   assign lu_hit_o     = lu_hit_q;
   assign lu_flow_id_o = lu_flow_id_q;
   assign lu_hash_o    = lu_hash_q;

`ifdef LH_LOOKUP_STATS_EN
   logic [15:0] drop_cnt_q;
   logic [15:0] hit_cnt_q;
   logic        drop_s;
   logic        hit_xfer_s;

   assign drop_s     = lh_valid_i && fifo_full_s && !pop_s;
   assign hit_xfer_s = lu_valid_q && lu_ready_i && lu_hit_q;

   // Saturating drop and hit statistics.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_q <= 16'h0000;
         hit_cnt_q  <= 16'h0000;
      end else begin
         if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'h0001;
         end
         if (hit_xfer_s && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'h0001;
         end
      end
   end

   assign drop_cnt_o = drop_cnt_q;
   assign hit_cnt_o  = hit_cnt_q;
`else
   assign drop_cnt_o = 16'h0000;
   assign hit_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_lh_lookup.sv
// Directed self-checking bench for lh_lookup with a behavioural two-cycle flow table.
module tb_lh_lookup;
   localparam int HW = 16;
   localparam int AW = 10;
   localparam int FW = 12;
   localparam int TW = HW - AW;
   localparam int DW = 1 + TW + FW;
`ifdef LH_LOOKUP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lh_valid = 1'b0;
   logic [HW-1:0] lh_data = '0;
   logic          tbl_rd_en;
   logic [AW-1:0] tbl_rd_addr;
   logic [DW-1:0] tbl_rd_data;
   logic          lu_valid;
   logic          lu_ready = 1'b0;
   logic          lu_hit;
   logic [FW-1:0] lu_flow_id;
   logic [HW-1:0] lu_hash;
   logic [15:0]   drop_cnt;
   logic [15:0]   hit_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_hits = 16'h0000;
   logic [15:0] exp_drops = 16'h0000;

   logic [DW-1:0] tbl [1024];
   logic [1:0]    pv = 2'b00;
   logic [DW-1:0] pd0, pd1;

   always #5 clk = ~clk;

   lh_lookup #(
      .LOGIC_HASH_NBITS(HW), .TBL_AW(AW), .FLOW_ID_NBITS(FW), .FIFO_DEPTH(4), .RD_LAT(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .lh_valid_i(lh_valid), .lh_data_i(lh_data),
      .tbl_rd_en_o(tbl_rd_en), .tbl_rd_addr_o(tbl_rd_addr), .tbl_rd_data_i(tbl_rd_data),
      .lu_valid_o(lu_valid), .lu_ready_i(lu_ready), .lu_hit_o(lu_hit),
      .lu_flow_id_o(lu_flow_id), .lu_hash_o(lu_hash),
      .drop_cnt_o(drop_cnt), .hit_cnt_o(hit_cnt)
   );

   // Table returns data two cycles after the strobe; outside that slot it drives a hit-looking junk word.
   always @(posedge clk) begin
      pv[0] <= tbl_rd_en;
      pd0   <= tbl[tbl_rd_addr];
      pv[1] <= pv[0];
      pd1   <= pd0;
   end
   assign tbl_rd_data = pv[1] ? pd1 : {DW{1'b1}};

   function automatic logic [HW-1:0] mk(input logic [TW-1:0] tag, input logic [AW-1:0] addr);
      return {tag, addr};
   endfunction

   function automatic logic [DW-1:0] ent(input logic v, input logic [TW-1:0] tag, input logic [FW-1:0] fl);
      return {v, tag, fl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [HW-1:0] h);
      lh_valid = 1'b1;
      lh_data  = h;
      step();
      lh_valid = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (lu_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lu_ready = 1'b0;
      step(); step(); step();
      n_cmp++; if ({lu_valid, lu_hit, tbl_rd_en} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags: got %b want 000", {lu_valid, lu_hit, tbl_rd_en}); end
      n_cmp++; if (lu_flow_id !== 12'h000) begin
         n_err++; $display("FAIL reset_flow: got %h want 000", lu_flow_id); end
      n_cmp++; if (lu_hash !== 16'h0000) begin
         n_err++; $display("FAIL reset_hash: got %h want 0000", lu_hash); end
      n_cmp++; if ({drop_cnt, hit_cnt} !== 32'h0) begin
         n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", drop_cnt, hit_cnt); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_hit();
      lu_ready = 1'b1;
      tbl[10'h005] = ent(1'b1, 6'h3A, 12'h123);
      n_cmp++; if (tbl_rd_en !== 1'b0) begin
         n_err++; $display("FAIL hit_rd_en_c0: got %b want 0", tbl_rd_en); end
      pulse(mk(6'h3A, 10'h005));
      n_cmp++; if ({tbl_rd_en, tbl_rd_addr} !== {1'b1, 10'h005}) begin
         n_err++; $display("FAIL hit_rd_c1: got %b/%h want 1/005", tbl_rd_en, tbl_rd_addr); end
      step();
      n_cmp++; if ({tbl_rd_en, lu_valid} !== 2'b00) begin
         n_err++; $display("FAIL hit_c2: got %b want 00", {tbl_rd_en, lu_valid}); end
      step();
      n_cmp++; if (lu_valid !== 1'b0) begin
         n_err++; $display("FAIL hit_valid_c3: got %b want 0", lu_valid); end
      step();
      n_cmp++; if ({lu_valid, lu_hit, lu_flow_id, lu_hash} !== {1'b1, 1'b1, 12'h123, 16'hE805}) begin
         n_err++; $display("FAIL hit_result_c4: got v%b h%b f%h x%h want v1 h1 f123 xE805",
                           lu_valid, lu_hit, lu_flow_id, lu_hash); end
      exp_hits++;
      step();
      n_cmp++; if (lu_valid !== 1'b0) begin
         n_err++; $display("FAIL hit_valid_c5: got %b want 0", lu_valid); end
      n_cmp++; if (hit_cnt !== (STATS ? exp_hits : 16'h0)) begin
         n_err++; $display("FAIL hit_cnt_single: got %h want %h", hit_cnt, STATS ? exp_hits : 16'h0); end
   endtask

   task automatic test_miss();
      bit ok;
      lu_ready = 1'b1;
      tbl[10'h005] = ent(1'b1, 6'h3B, 12'h123);
      pulse(mk(6'h3A, 10'h005));
      wait_valid(10, ok);
      n_cmp++; if ({ok, lu_hit, lu_flow_id, lu_hash} !== {1'b1, 1'b0, 12'h000, 16'hE805}) begin
         n_err++; $display("FAIL miss_tag: got ok%b h%b f%h x%h want ok1 h0 f000 xE805",
                           ok, lu_hit, lu_flow_id, lu_hash); end
      step();
      tbl[10'h005] = ent(1'b0, 6'h3A, 12'h123);
      pulse(mk(6'h3A, 10'h005));
      wait_valid(10, ok);
      n_cmp++; if ({ok, lu_hit, lu_flow_id} !== {1'b1, 1'b0, 12'h000}) begin
         n_err++; $display("FAIL miss_invalid: got ok%b h%b f%h want ok1 h0 f000", ok, lu_hit, lu_flow_id); end
      step();
   endtask

   task automatic test_backpressure();
      bit ok;
      tbl[10'h010] = ent(1'b1, 6'h01, 12'h456);
      tbl[10'h011] = ent(1'b1, 6'h02, 12'h789);
      lu_ready = 1'b0;
      pulse(mk(6'h01, 10'h010));
      pulse(mk(6'h02, 10'h011));
      wait_valid(10, ok);
      n_cmp++; if (ok !== 1'b1) begin
         n_err++; $display("FAIL bp_first_valid: got timeout want lu_valid"); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if ({lu_valid, lu_hit, lu_flow_id, lu_hash, tbl_rd_en} !== {1'b1, 1'b1, 12'h456, mk(6'h01, 10'h010), 1'b0}) begin
            n_err++; $display("FAIL bp_hold_%0d: got v%b h%b f%h x%h r%b want v1 h1 f456 x%h r0",
                              i, lu_valid, lu_hit, lu_flow_id, lu_hash, tbl_rd_en, mk(6'h01, 10'h010)); end
         step();
      end
      lu_ready = 1'b1;
      exp_hits++;
      step();
      n_cmp++; if ({lu_valid, tbl_rd_en, tbl_rd_addr} !== {1'b0, 1'b1, 10'h011}) begin
         n_err++; $display("FAIL bp_next_read: got v%b r%b a%h want v0 r1 a011", lu_valid, tbl_rd_en, tbl_rd_addr); end
      wait_valid(10, ok);
      n_cmp++; if ({ok, lu_hit, lu_flow_id, lu_hash} !== {1'b1, 1'b1, 12'h789, mk(6'h02, 10'h011)}) begin
         n_err++; $display("FAIL bp_second: got ok%b h%b f%h x%h want ok1 h1 f789 x%h",
                           ok, lu_hit, lu_flow_id, lu_hash, mk(6'h02, 10'h011)); end
      exp_hits++;
      step();
   endtask

   task automatic test_overflow();
      bit ok;
      bit stray;
      for (int i = 0; i < 6; i++) tbl[10'h020 + i] = ent(1'b1, 6'h02, 12'h200 + 12'(i));
      lu_ready = 1'b0;
      for (int i = 0; i < 6; i++) pulse(mk(6'h02, 10'h020 + 10'(i)));
      exp_drops++;
      n_cmp++; if (drop_cnt !== (STATS ? exp_drops : 16'h0)) begin
         n_err++; $display("FAIL ovf_drop_cnt: got %h want %h", drop_cnt, STATS ? exp_drops : 16'h0); end
      lu_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_valid(20, ok);
         n_cmp++;
         if ({ok, lu_hash, lu_flow_id} !== {1'b1, mk(6'h02, 10'h020 + 10'(k)), 12'h200 + 12'(k)}) begin
            n_err++; $display("FAIL ovf_result_%0d: got ok%b x%h f%h want ok1 x%h f%h", k, ok, lu_hash,
                              lu_flow_id, mk(6'h02, 10'h020 + 10'(k)), 12'h200 + 12'(k)); end
         exp_hits++;
         step();
      end
      stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (lu_valid !== 1'b0) stray = 1'b1;
         step();
      end
      n_cmp++; if (stray !== 1'b0) begin
         n_err++; $display("FAIL ovf_no_sixth: got extra result want none"); end
      n_cmp++; if ({drop_cnt, hit_cnt} !== (STATS ? {exp_drops, exp_hits} : 32'h0)) begin
         n_err++; $display("FAIL ovf_counters: got %h/%h want %h", drop_cnt, hit_cnt,
                           STATS ? {exp_drops, exp_hits} : 32'h0); end
   endtask

   task automatic test_full_boundary();
      bit ok;
      for (int i = 0; i < 6; i++) tbl[10'h030 + i] = ent(1'b1, 6'h03, 12'h300 + 12'(i));
      lu_ready = 1'b0;
      for (int i = 0; i < 5; i++) pulse(mk(6'h03, 10'h030 + 10'(i)));
      n_cmp++; if ({lu_valid, lu_hash} !== {1'b1, mk(6'h03, 10'h030)}) begin
         n_err++; $display("FAIL full_first: got v%b x%h want v1 x%h", lu_valid, lu_hash, mk(6'h03, 10'h030)); end
      lu_ready = 1'b1;
      exp_hits++;
      step();
      lu_ready = 1'b0;
      n_cmp++; if ({tbl_rd_en, tbl_rd_addr} !== {1'b1, 10'h031}) begin
         n_err++; $display("FAIL full_pop_cycle: got r%b a%h want r1 a031", tbl_rd_en, tbl_rd_addr); end
      pulse(mk(6'h03, 10'h035));
      n_cmp++; if (drop_cnt !== (STATS ? exp_drops : 16'h0)) begin
         n_err++; $display("FAIL full_no_drop: got %h want %h", drop_cnt, STATS ? exp_drops : 16'h0); end
      lu_ready = 1'b1;
      for (int k = 1; k < 6; k++) begin
         wait_valid(20, ok);
         n_cmp++;
         if ({ok, lu_hash, lu_flow_id} !== {1'b1, mk(6'h03, 10'h030 + 10'(k)), 12'h300 + 12'(k)}) begin
            n_err++; $display("FAIL full_result_%0d: got ok%b x%h f%h want ok1 x%h f%h", k, ok, lu_hash,
                              lu_flow_id, mk(6'h03, 10'h030 + 10'(k)), 12'h300 + 12'(k)); end
         exp_hits++;
         step();
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      bit stray;
      lu_ready = 1'b1;
      tbl[10'h005] = ent(1'b1, 6'h3A, 12'h123);
      pulse(mk(6'h3A, 10'h005));
      n_cmp++; if (tbl_rd_en !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_rd_en: got %b want 1", tbl_rd_en); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_hits = 16'h0000;
      exp_drops = 16'h0000;
      n_cmp++; if ({drop_cnt, hit_cnt} !== 32'h0) begin
         n_err++; $display("FAIL rst_mid_counters: got %h/%h want 0/0", drop_cnt, hit_cnt); end
      stray = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if ({lu_valid, tbl_rd_en} !== 2'b00) stray = 1'b1;
         step();
      end
      n_cmp++; if (stray !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_quiet: got activity after reset want none"); end
      pulse(mk(6'h3A, 10'h005));
      wait_valid(10, ok);
      n_cmp++; if ({ok, lu_hit, lu_flow_id, lu_hash} !== {1'b1, 1'b1, 12'h123, 16'hE805}) begin
         n_err++; $display("FAIL rst_mid_after: got ok%b h%b f%h x%h want ok1 h1 f123 xE805",
                           ok, lu_hit, lu_flow_id, lu_hash); end
      exp_hits++;
      step();
      n_cmp++; if ({drop_cnt, hit_cnt} !== (STATS ? {exp_drops, exp_hits} : 32'h0)) begin
         n_err++; $display("FAIL rst_mid_hit_cnt: got %h/%h want %h", drop_cnt, hit_cnt,
                           STATS ? {exp_drops, exp_hits} : 32'h0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) tbl[i] = '0;
      test_reset();
      test_single_hit();
      test_miss();
      test_backpressure();
      test_overflow();
      test_full_boundary();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
